// File: rtl/collision_move_if.sv
// rtl/collision_move_if.sv - map read port between the mover and the maze store
interface collision_move_if #(
    parameter int ADDR_W = 10
);
    logic              map_rd_en;
    logic [ADDR_W-1:0] map_addr;
    logic [3:0]        map_data;

    modport master (output map_rd_en, output map_addr, input map_data);
    modport slave  (input map_rd_en, input map_addr, output map_data);
endinterface

// File: rtl/collision_move.sv
// rtl/collision_move.sv - fixed-latency per-axis collision-checked player move
module collision_move #(
    parameter int          MAP_SIZE    = 24,
    parameter logic [15:0] MOVE_STEP   = 16'h0040,
    parameter int          MAP_LATENCY = 2,
    parameter logic [15:0] START_X     = 16'h0180,
    parameter logic [15:0] START_Y     = 16'h0180
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                fwd_pulse,
    input  logic                bwd_pulse,
    input  logic signed [15:0]  dirX,
    input  logic signed [15:0]  dirY,
    collision_move_if.master    map,
    output logic [15:0]         posX,
    output logic [15:0]         posY,
    output logic                busy,
    output logic                move_done,
    output logic [1:0]          bumped
);
    localparam int                 ADDR_W = $clog2(MAP_SIZE * MAP_SIZE);
    localparam logic [8:0]         MAP_SIZE_9 = 9'(MAP_SIZE);
    localparam logic [7:0]         MAP_SIZE_8 = 8'(MAP_SIZE);
    localparam logic [2:0]         LAT = 3'(MAP_LATENCY);
    localparam logic signed [31:0] STEP_S = {16'b0, MOVE_STEP};

    typedef enum logic [2:0] {IDLE, CALC, RD_X, WAIT_X, RD_Y, WAIT_Y, COMMIT} state_t;
    state_t state, state_nx;

    logic signed [15:0] dx_q, dy_q;
    logic               neg_q;
    logic [16:0]        cand_x, cand_y;
    logic [2:0]         wait_cnt;
    logic               x_blk, y_blk;
    logic               accept, x_oor, y_oor;
    logic signed [31:0] prod_x, prod_y;
    logic [15:0]        step_x, step_y, delta_x, delta_y;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] cy, input logic [7:0] cx);
        return ADDR_W'({8'b0, cy} * {8'b0, MAP_SIZE_8} + {8'b0, cx});
    endfunction

    // busy stays high through the move_done cycle, so only a fully idle block takes a pulse
    assign accept = (state == IDLE) && !busy && (fwd_pulse || bwd_pulse);

    assign prod_x  = 32'(dx_q) * STEP_S;
    assign prod_y  = 32'(dy_q) * STEP_S;
    assign step_x  = 16'(prod_x >>> 8);
    assign step_y  = 16'(prod_y >>> 8);
    assign delta_x = neg_q ? 16'(-step_x) : step_x;
    assign delta_y = neg_q ? 16'(-step_y) : step_y;

    assign x_oor = cand_x[16] || ({1'b0, cand_x[15:8]} >= MAP_SIZE_9);
    assign y_oor = cand_y[16] || ({1'b0, cand_y[15:8]} >= MAP_SIZE_9);

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        map.map_rd_en = 1'b0;
        map.map_addr  = '0;
        case (state)
            IDLE:   if (accept) state_nx = CALC;
            CALC:   state_nx = RD_X;
            RD_X: begin
                map.map_rd_en = 1'b1;
                map.map_addr  = x_oor ? '0 : cell_addr(posY[15:8], cand_x[15:8]);
                state_nx      = WAIT_X;
            end
            WAIT_X: if (wait_cnt == LAT) state_nx = RD_Y;
            RD_Y: begin
                map.map_rd_en = 1'b1;
                map.map_addr  = y_oor ? '0 : cell_addr(cand_y[15:8], posX[15:8]);
                state_nx      = WAIT_Y;
            end
            WAIT_Y: if (wait_cnt == LAT) state_nx = COMMIT;
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            posX      <= START_X;
            posY      <= START_Y;
            busy      <= 1'b0;
            move_done <= 1'b0;
            bumped    <= 2'b00;
            dx_q      <= '0;
            dy_q      <= '0;
            neg_q     <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
            wait_cnt  <= '0;
            x_blk     <= 1'b0;
            y_blk     <= 1'b0;
        end else begin
            move_done <= 1'b0;
            if (move_done) busy <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    dx_q  <= dirX;
                    dy_q  <= dirY;
                    neg_q <= !fwd_pulse;
                    busy  <= 1'b1;
                end
                CALC: begin
                    cand_x <= {1'b0, posX} + {delta_x[15], delta_x};
                    cand_y <= {1'b0, posY} + {delta_y[15], delta_y};
                end
                RD_X, RD_Y: wait_cnt <= 3'd1;
                WAIT_X: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == LAT) x_blk <= (map.map_data != 4'd0) || x_oor;
                end
                WAIT_Y: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == LAT) y_blk <= (map.map_data != 4'd0) || y_oor;
                end
                COMMIT: begin
                    if (!x_blk) posX <= cand_x[15:0];
                    if (!y_blk) posY <= cand_y[15:0];
                    bumped    <= {y_blk, x_blk};
                    move_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
